// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Multi-cycle unsigned magnitude comparator. Operands are captured on start
//   and then walked two bits per clock, MSB slice first. The first unequal
//   slice decides the result, so a comparison finishes early when the
//   operands differ high up. A tie is declared once the last slice has been
//   compared equal.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   comparison request, sampled only while idle
//     a, b   in   WIDTH-bit unsigned operands, captured when start is accepted
//     busy   out  comparison in progress
//     done   out  one-cycle pulse; G/L/E are valid from this cycle on
//     G/L/E  out  A > B / A < B / A == B, held until the next start is accepted
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; G/L/E hold the last result
//   RUN   | comparing one 2-bit slice per clock, MSB slice first

module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             G,
    output logic             L,
    output logic             E
);

    localparam int S  = WIDTH / 2;
    // S == 1 would give a zero-width counter; keep at least one bit.
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(S - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    logic x1, x0, y1, y0;
    logic gs, ls;

    // The current slice is always the top two bits; the registers shift left.
    assign x1 = sa_q[WIDTH-1];
    assign x0 = sa_q[WIDTH-2];
    assign y1 = sb_q[WIDTH-1];
    assign y0 = sb_q[WIDTH-2];

    assign gs = (x1 & ~y1) | ((x1 ~^ y1) & x0 & ~y0);
    assign ls = (~x1 & y1) | ((x1 ~^ y1) & ~x0 & y0);

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    cnt_d   = CNT_INIT;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (gs) begin
                    g_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ls) begin
                    l_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    // Every slice matched, including this last one.
                    e_d     = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    sa_d  = sa_q << 2;
                    sb_d  = sb_q << 2;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign G    = g_q;
    assign L    = l_q;
    assign E    = e_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
module tb_serial_mag_comp;

    localparam int W = 8;
    localparam int S = W / 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         G;
    logic         L;
    logic         E;

    int n_tests;
    int n_fail;
    logic [2:0] last_gle;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .G     (G),
        .L     (L),
        .E     (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Number of clocks to a decision: 1-based index of the first differing
    // 2-bit digit counted from the most significant end, or S on a tie.
    function automatic int exp_k(input logic [W-1:0] av, input logic [W-1:0] bv);
        int da, db;
        for (int i = 0; i < S; i++) begin
            da = (int'(av) / (1 << (W - 2 - 2 * i))) % 4;
            db = (int'(bv) / (1 << (W - 2 - 2 * i))) % 4;
            if (da != db) return i + 1;
        end
        return S;
    endfunction

    function automatic logic [2:0] exp_gle(input logic [W-1:0] av, input logic [W-1:0] bv);
        return {av > bv, av < bv, av == bv};
    endfunction

    // Entered 1 time unit after a clock edge with the DUT idle. Returns 1 time
    // unit after the deciding edge (the done cycle) with start low.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit hold, input bit perturb);
        int k;
        k = exp_k(av, bv);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk); #1;
        start = hold;
        for (int c = 1; c <= k; c++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_gle",  32'({G, L, E}), 32'd0);
            if (perturb) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        last_gle = exp_gle(av, bv);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy",  32'(busy), 32'd0);
        chk("done_gle",   32'({G, L, E}), 32'(last_gle));
    endtask

    task automatic check_hold();
        @(posedge clk); #1;
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_busy", 32'(busy), 32'd0);
        chk("hold_gle",  32'({G, L, E}), 32'(last_gle));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        n_tests  = 0;
        n_fail   = 0;
        last_gle = 3'b000;
        rst_n    = 1'b0;
        start    = 1'b1;
        a        = 8'hA5;
        b        = 8'h5A;

        // Reset held with start asserted.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_gle",  32'({G, L, E}), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_gle",  32'({G, L, E}), 32'd0);
        end

        // Directed cases.
        run_cmp(8'hA5, 8'hA5, 1'b0, 1'b0); check_hold(); check_hold();
        run_cmp(8'hC0, 8'h40, 1'b0, 1'b0); check_hold();
        run_cmp(8'h12, 8'h13, 1'b0, 1'b0); check_hold();
        run_cmp(8'h34, 8'h38, 1'b1, 1'b1); check_hold();

        // Back-to-back: second start issued in the done cycle of the first.
        run_cmp(8'h34, 8'h38, 1'b0, 1'b0);
        run_cmp(8'hFF, 8'h00, 1'b0, 1'b0); check_hold();

        // Reset in the middle of a run.
        start = 1'b1; a = 8'h55; b = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_gle",  32'({G, L, E}), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_cmp(8'h55, 8'h55, 1'b0, 1'b0); check_hold();

        // Randomized, with ties and single-digit differences biased in.
        for (int n = 0; n < 300; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run_cmp(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) check_hold();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
